// File: rtl/mezz_jtag_pkg.sv
// mezz_jtag_pkg: TAP state encoding, IR codes and the per-instruction DR table
package mezz_jtag_pkg;

   typedef enum logic [3:0] {
      EXIT2_DR         = 4'h0,
      EXIT1_DR         = 4'h1,
      SHIFT_DR         = 4'h2,
      PAUSE_DR         = 4'h3,
      SELECT_IR        = 4'h4,
      UPDATE_DR        = 4'h5,
      CAPTURE_DR       = 4'h6,
      SELECT_DR        = 4'h7,
      EXIT2_IR         = 4'h8,
      EXIT1_IR         = 4'h9,
      SHIFT_IR         = 4'hA,
      PAUSE_IR         = 4'hB,
      RUN_TEST_IDLE    = 4'hC,
      UPDATE_IR        = 4'hD,
      CAPTURE_IR       = 4'hE,
      TEST_LOGIC_RESET = 4'hF
   } tap_state_t;

   localparam logic [4:0] IDCODE   = 5'h11;
   localparam logic [4:0] ASDWRITE = 5'h09;
   localparam logic [4:0] ASDREAD  = 5'h0A;
   localparam logic [4:0] SETUP0   = 5'h12;
   localparam logic [4:0] SETUP1   = 5'h13;
   localparam logic [4:0] SETUP2   = 5'h14;
   localparam logic [4:0] CONTROL0 = 5'h15;
   localparam logic [4:0] CONTROL1 = 5'h16;
   localparam logic [4:0] STATUS0  = 5'h17;
   localparam logic [4:0] STATUS1  = 5'h18;
   localparam logic [4:0] BYPASS   = 5'h1F;

   typedef struct packed {
      logic [8:0] len;
      logic       wr;
      logic       rb;
   } dr_info_t;

   // status DRs carry {9-bit shift count, 5-bit tag}; anything unlisted behaves as BYPASS
   function automatic dr_info_t dr_len(input logic [4:0] ir);
      case (ir)
         IDCODE:   return {9'd32, 1'b0, 1'b0};
         ASDWRITE: return {9'd256, 1'b1, 1'b0};
         ASDREAD:  return {9'd256, 1'b0, 1'b1};
         SETUP0:   return {9'd64, 1'b1, 1'b0};
         SETUP1:   return {9'd32, 1'b1, 1'b0};
         SETUP2:   return {9'd16, 1'b1, 1'b0};
         CONTROL0: return {9'd8, 1'b1, 1'b0};
         CONTROL1: return {9'd12, 1'b1, 1'b0};
         STATUS0:  return {9'd14, 1'b0, 1'b0};
         STATUS1:  return {9'd14, 1'b0, 1'b0};
         default:  return {9'd1, 1'b0, 1'b0};
      endcase
   endfunction

endpackage

// File: rtl/mezz_jtag_tap_fsm.sv
// mezz_jtag_tap_fsm: IEEE 1149.1 TAP controller stepped by a synchronized tck rise
module mezz_jtag_tap_fsm
   import mezz_jtag_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       tms,
   output tap_state_t state,
   output logic       capture_ir,
   output logic       shift_ir,
   output logic       update_ir,
   output logic       capture_dr,
   output logic       shift_dr,
   output logic       update_dr,
   output logic       tlr
);

   tap_state_t state_nx;

   // state register, moves only on a tck rise
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= TEST_LOGIC_RESET;
      else if (en) state <= state_nx;

   // standard 16-state transition table
   always_comb
      case (state)
         TEST_LOGIC_RESET: state_nx = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
         RUN_TEST_IDLE:    state_nx = tms ? SELECT_DR : RUN_TEST_IDLE;
         SELECT_DR:        state_nx = tms ? SELECT_IR : CAPTURE_DR;
         CAPTURE_DR:       state_nx = tms ? EXIT1_DR : SHIFT_DR;
         SHIFT_DR:         state_nx = tms ? EXIT1_DR : SHIFT_DR;
         EXIT1_DR:         state_nx = tms ? UPDATE_DR : PAUSE_DR;
         PAUSE_DR:         state_nx = tms ? EXIT2_DR : PAUSE_DR;
         EXIT2_DR:         state_nx = tms ? UPDATE_DR : SHIFT_DR;
         UPDATE_DR:        state_nx = tms ? SELECT_DR : RUN_TEST_IDLE;
         SELECT_IR:        state_nx = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
         CAPTURE_IR:       state_nx = tms ? EXIT1_IR : SHIFT_IR;
         SHIFT_IR:         state_nx = tms ? EXIT1_IR : SHIFT_IR;
         EXIT1_IR:         state_nx = tms ? UPDATE_IR : PAUSE_IR;
         PAUSE_IR:         state_nx = tms ? EXIT2_IR : PAUSE_IR;
         EXIT2_IR:         state_nx = tms ? UPDATE_IR : SHIFT_IR;
         UPDATE_IR:        state_nx = tms ? SELECT_DR : RUN_TEST_IDLE;
         default:          state_nx = TEST_LOGIC_RESET;
      endcase

   // per-state action strobes for the datapath
   always_comb begin
      capture_ir = state == CAPTURE_IR;
      shift_ir   = state == SHIFT_IR;
      update_ir  = state == UPDATE_IR;
      capture_dr = state == CAPTURE_DR;
      shift_dr   = state == SHIFT_DR;
      update_dr  = state == UPDATE_DR;
      tlr        = state == TEST_LOGIC_RESET;
   end

endmodule

// File: rtl/mezz_jtag_tap_responder.sv
// mezz_jtag_tap_responder: oversampled JTAG TAP target with loop-back shadow DR; MEZZ_TAP_ERRINJ_EN adds TDO error injection
module mezz_jtag_tap_responder
   import mezz_jtag_pkg::*;
#(
   parameter int          IR_LEN       = 5,
   parameter int          DR_MAX       = 256,
   parameter logic [31:0] IDCODE_VALUE = 32'h8B8A_C3B1,
   parameter int          SYNC_STAGES  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tck,
   input  logic              tms,
   input  logic              tdi,
   output logic              tdo,
   output logic              tdo_oe,
   output tap_state_t        tap_state,
   output logic [IR_LEN-1:0] instr,
   output logic              update_pulse,
   output logic [IR_LEN-1:0] update_instr,
   output logic [DR_MAX-1:0] update_data,
   output logic              dr_overrun
`ifdef MEZZ_TAP_ERRINJ_EN
   ,
   input  logic              errinj,
   input  logic [8:0]        errinj_bit
`endif
);

   localparam int AW = $clog2(DR_MAX);
   localparam int CW = $clog2(DR_MAX + 1);

   logic [SYNC_STAGES-1:0] tck_q, tms_q, tdi_q;
   logic tck_d, tck_s, tms_s, tdi_s, tck_rise, tck_fall, inj;
   logic capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr, tlr;
   logic [IR_LEN-1:0] ir_sh, tag;
   logic [DR_MAX-1:0] dr_sh, sh_next, cap_val, mask;
   logic [CW-1:0] cnt;
   dr_info_t info;

   assign tck_s    = tck_q[SYNC_STAGES-1];
   assign tms_s    = tms_q[SYNC_STAGES-1];
   assign tdi_s    = tdi_q[SYNC_STAGES-1];
   assign tck_rise = tck_s & ~tck_d;
   assign tck_fall = ~tck_s & tck_d;
   assign info     = dr_len(instr);
   assign mask     = {DR_MAX{1'b1}} >> (DR_MAX - int'(info.len));

`ifdef MEZZ_TAP_ERRINJ_EN
   assign inj = errinj && shift_dr && cnt == errinj_bit;
`else
   assign inj = 1'b0;
`endif

   // bring the JTAG pins into the clk domain and keep the last tck for edge detection
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         tck_q <= '0;
         tms_q <= '0;
         tdi_q <= '0;
         tck_d <= 1'b0;
      end else begin
         tck_q <= {tck_q[SYNC_STAGES-2:0], tck};
         tms_q <= {tms_q[SYNC_STAGES-2:0], tms};
         tdi_q <= {tdi_q[SYNC_STAGES-2:0], tdi};
         tck_d <= tck_s;
      end

   mezz_jtag_tap_fsm u_fsm (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (tck_rise),
      .tms        (tms_s),
      .state      (tap_state),
      .capture_ir (capture_ir),
      .shift_ir   (shift_ir),
      .update_ir  (update_ir),
      .capture_dr (capture_dr),
      .shift_dr   (shift_dr),
      .update_dr  (update_dr),
      .tlr        (tlr)
   );

   // Capture-DR value, trimmed to the active length; readback mirrors the last ASDWRITE
   always_comb
      cap_val = mask & (instr == IDCODE ? DR_MAX'(IDCODE_VALUE)
              : (instr == STATUS0 || instr == STATUS1) ? DR_MAX'({cnt, tag})
              : ((info.wr && tag == instr) || (info.rb && tag == ASDWRITE)) ? update_data : '0);

   // shift toward bit 0, new tdi enters at the top of the active length
   always_comb begin
      sh_next = dr_sh >> 1;
      sh_next[AW'(info.len - 9'd1)] = tdi_s;
   end

   // capture/shift on tck rise, tdo and update on tck fall, TLR drops the shifters
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ir_sh        <= '0;
         instr        <= IDCODE;
         dr_sh        <= '0;
         update_data  <= '0;
         tag          <= '0;
         cnt          <= '0;
         tdo          <= 1'b0;
         tdo_oe       <= 1'b0;
         update_pulse <= 1'b0;
         update_instr <= '0;
         dr_overrun   <= 1'b0;
      end else begin
         update_pulse <= 1'b0;
         if (tck_rise) begin
            if (capture_ir) ir_sh <= IR_LEN'(1);
            if (shift_ir) ir_sh <= {tdi_s, ir_sh[IR_LEN-1:1]};
            if (capture_dr) begin
               dr_sh <= cap_val;
               cnt   <= '0;
            end
            if (shift_dr) begin
               dr_sh <= sh_next;
               cnt   <= cnt == CW'(DR_MAX) ? cnt : cnt + 1'b1;
               if (cnt >= CW'(info.len)) dr_overrun <= 1'b1;
            end
         end
         if (tck_fall) begin
            tdo    <= shift_ir ? ir_sh[0] : dr_sh[0] ^ inj;
            tdo_oe <= shift_ir | shift_dr;
            if (update_ir) instr <= ir_sh;
            if (update_dr && info.wr) begin
               update_data  <= dr_sh & mask;
               tag          <= instr;
               update_pulse <= 1'b1;
               update_instr <= instr;
            end
         end
         if (tlr) begin
            instr <= IDCODE;
            ir_sh <= '0;
            dr_sh <= '0;
         end
      end

endmodule
